// File: rtl/mostra_sequencia_jogadas_pkg.sv
// Shared state codes for the sequence presenter.
// The same codes feed the hexa7seg debug display.
package mostra_sequencia_jogadas_pkg;

   localparam logic [3:0] ST_INICIAL    = 4'd0;
   localparam logic [3:0] ST_PREPARACAO = 4'd1;
   localparam logic [3:0] ST_ACENDE     = 4'd2;
   localparam logic [3:0] ST_APAGA      = 4'd3;
   localparam logic [3:0] ST_PROXIMO    = 4'd4;
   localparam logic [3:0] ST_FINAL      = 4'd15;

   // True while the sequence is being presented.
   function automatic logic em_exibicao(input logic [3:0] e);
      return (e == ST_PREPARACAO) || (e == ST_ACENDE) ||
             (e == ST_APAGA) || (e == ST_PROXIMO);
   endfunction

endpackage

// File: rtl/mostra_sequencia_jogadas_contador_tempo.sv
// Free-running timer with clear/enable and terminal count.
// Wraps to zero on its own after the terminal cycle.
module contador_tempo
   import mostra_sequencia_jogadas_pkg::*;
#(
   parameter int M = 1000
) (
   input  logic clock,
   input  logic reset,
   input  logic zera,
   input  logic conta,
   output logic fim
);

   localparam int W = (M > 1) ? $clog2(M) : 1;
   localparam logic [W-1:0] MAX = W'(M - 1);

   logic [W-1:0] r_cnt;

   // Count enabled cycles, wrapping at the terminal value.
   always_ff @(posedge clock) begin
      if (reset || zera) begin
         r_cnt <= '0;
      end else if (conta) begin
         if (r_cnt == MAX) r_cnt <= '0;
         else              r_cnt <= r_cnt + 1'b1;
      end
   end

   assign fim = (r_cnt == MAX);

endmodule

// File: rtl/mostra_sequencia_jogadas.sv
// Memory-game sequence presenter: walks addresses 0..limite,
// lighting each jogada for T_ACESO then blanking for T_APAGADO.
module mostra_sequencia_jogadas
   import mostra_sequencia_jogadas_pkg::*;
#(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 500
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   input  logic [3:0] dado_memoria,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       mostrando,
   output logic       pronto,
   output logic [3:0] db_estado
);

   logic [3:0] r_estado;
   logic [3:0] w_prox;
   logic [3:0] r_endereco;
   logic [3:0] r_limite;
   logic       w_fim_aceso;
   logic       w_fim_apagado;
   logic       w_zera;

   assign w_zera = (r_estado == ST_PREPARACAO);

   contador_tempo #(.M(T_ACESO)) u_t_aceso (
      .clock (clock),
      .reset (reset),
      .zera  (w_zera),
      .conta (r_estado == ST_ACENDE),
      .fim   (w_fim_aceso)
   );

   contador_tempo #(.M(T_APAGADO)) u_t_apagado (
      .clock (clock),
      .reset (reset),
      .zera  (w_zera),
      .conta (r_estado == ST_APAGA),
      .fim   (w_fim_apagado)
   );

   // Next-state decode; unused codes fall back to inicial.
   always_comb begin
      w_prox = ST_INICIAL;
      case (r_estado)
         ST_INICIAL:
            w_prox = iniciar ? ST_PREPARACAO : ST_INICIAL;
         ST_PREPARACAO:
            w_prox = ST_ACENDE;
         ST_ACENDE:
            w_prox = w_fim_aceso ? ST_APAGA : ST_ACENDE;
         ST_APAGA:
            if (!w_fim_apagado)
               w_prox = ST_APAGA;
            else if (r_endereco == r_limite)
               w_prox = ST_FINAL;
            else
               w_prox = ST_PROXIMO;
         ST_PROXIMO:
            w_prox = ST_ACENDE;
         ST_FINAL:
            w_prox = ST_INICIAL;
         default:
            w_prox = ST_INICIAL;
      endcase
   end

   // State register.
   always_ff @(posedge clock) begin
      if (reset) r_estado <= ST_INICIAL;
      else       r_estado <= w_prox;
   end

   // Address counter and latched limit; last-address check
   // precedes any increment, so 15 never wraps.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_endereco <= '0;
         r_limite   <= '0;
      end else if (r_estado == ST_PREPARACAO) begin
         r_endereco <= '0;
         r_limite   <= limite;
      end else if (r_estado == ST_PROXIMO) begin
         r_endereco <= r_endereco + 4'd1;
      end
   end

   assign endereco  = r_endereco;
   assign leds      = (r_estado == ST_ACENDE) ? dado_memoria : 4'd0;
   assign mostrando = em_exibicao(r_estado);
   assign pronto    = (r_estado == ST_FINAL);
   assign db_estado = r_estado;

endmodule
